// File: rtl/issue_scheduler_pkg.sv
// Shared types and helpers for the in-order issue scheduler.
// Defines the decoded instruction format from decode, the exception codes,
// the NOP decode constant, and predicates that derive register and unit
// usage from the opcode.
package issue_scheduler_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_LOAD, OP_STORE, OP_BRANCH, OP_MUL, OP_DIV
    } op_t;

    typedef enum logic [2:0] {
        EXCEPT_NONE, EXCEPT_ILLEGAL, EXCEPT_FETCH_FAULT, EXCEPT_MISALIGN
    } except_t;

    typedef struct packed {
        op_t              op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } decode_t;

    typedef struct packed {
        logic        valid;
        except_t     exc;
        decode_t     dec;
        logic [31:0] pc;
    } decoded_instr_t;

    localparam decode_t NOP_DECODE = '{op: OP_NOP, rd: '0, rs1: '0, rs2: '0};

    function automatic logic instr_uses_rs1(decode_t d);
        return d.op != OP_NOP;
    endfunction

    function automatic logic instr_uses_rs2(decode_t d);
        return d.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STORE,
                            OP_BRANCH, OP_MUL, OP_DIV};
    endfunction

    function automatic logic instr_writes_rd(decode_t d);
        return d.op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD,
                            OP_MUL, OP_DIV};
    endfunction

    function automatic logic instr_is_muldiv(decode_t d);
        return d.op inside {OP_MUL, OP_DIV};
    endfunction

endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
// Ports: i_clk/i_rst, writeback strobes and destinations (clear), one set
// request from the issue stage, rs1/rs2/rd lookups against the effective
// (writeback-cleared) scoreboard, and the registered pending vector.
module sched_scoreboard
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_WB   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_WB-1:0]             i_wb_valid,
    input  logic [NUM_WB-1:0][REG_W-1:0]  i_wb_rd,
    input  logic                          i_set_en,
    input  logic [REG_W-1:0]              i_set_rd,
    input  logic [REG_W-1:0]              i_rs1,
    input  logic [REG_W-1:0]              i_rs2,
    input  logic [REG_W-1:0]              i_rd,
    output logic                          o_rs1_pend,
    output logic                          o_rs2_pend,
    output logic                          o_rd_pend,
    output logic [NUM_REGS-1:0]           o_pending
);

    logic [NUM_REGS-1:0] sb_q, sb_d, wb_clear, sb_eff, set_vec;

    always_comb begin
        wb_clear = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (i_wb_valid[k]) wb_clear = wb_clear | (NUM_REGS'(1) << i_wb_rd[k]);
        end
        // Same-cycle writeback is visible to lookups so a waiter can issue now.
        sb_eff  = sb_q & ~wb_clear;
        set_vec = (i_set_en && i_set_rd != REG_ZERO) ? (NUM_REGS'(1) << i_set_rd) : '0;
        // OR-ing the set after the clear makes a new issue win over writeback.
        sb_d    = sb_eff | set_vec;
    end

    assign o_rs1_pend = (i_rs1 != REG_ZERO) && sb_eff[i_rs1];
    assign o_rs2_pend = (i_rs2 != REG_ZERO) && sb_eff[i_rs2];
    assign o_rd_pend  = (i_rd  != REG_ZERO) && sb_eff[i_rd];
    assign o_pending  = sb_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) sb_q <= '0;
        else       sb_q <= sb_d;
    end

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-issue scheduler between decode and execute.
// Holds the decode candidate (i_instr), stalls decode (o_stall) on RAW, WAW
// or mul/div structural hazards or when execute is not ready, and issues into
// a registered slot (o_issue). Writeback ports (i_wb_valid/i_wb_rd) clear
// scoreboard bits; i_md_done frees the mul/div unit; i_flush kills the slot
// and the candidate; o_sb_pending exposes the scoreboard.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_WB   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  decoded_instr_t                i_instr,
    output logic                          o_stall,
    input  logic                          i_ex_ready,
    output decoded_instr_t                o_issue,
    input  logic [NUM_WB-1:0]             i_wb_valid,
    input  logic [NUM_WB-1:0][REG_W-1:0]  i_wb_rd,
    input  logic                          i_md_done,
    output logic [NUM_REGS-1:0]           o_sb_pending
);

    decoded_instr_t issue_q;
    logic           md_busy_q;
    logic           regs_live, uses_rs1, uses_rs2, writes_rd, is_md;
    logic           rs1_pend, rs2_pend, rd_pend;
    logic           raw, waw, struct_haz, md_busy_eff, can_issue;

    // An excepting instruction carries no register or unit use, so it only
    // waits for execute and reaches it in program order.
    assign regs_live = i_instr.valid && (i_instr.exc == EXCEPT_NONE);
    assign uses_rs1  = regs_live && instr_uses_rs1(i_instr.dec);
    assign uses_rs2  = regs_live && instr_uses_rs2(i_instr.dec);
    assign writes_rd = regs_live && instr_writes_rd(i_instr.dec);
    assign is_md     = regs_live && instr_is_muldiv(i_instr.dec);

    sched_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wb_valid (i_wb_valid),
        .i_wb_rd    (i_wb_rd),
        .i_set_en   (can_issue && writes_rd),
        .i_set_rd   (i_instr.dec.rd),
        .i_rs1      (i_instr.dec.rs1),
        .i_rs2      (i_instr.dec.rs2),
        .i_rd       (i_instr.dec.rd),
        .o_rs1_pend (rs1_pend),
        .o_rs2_pend (rs2_pend),
        .o_rd_pend  (rd_pend),
        .o_pending  (o_sb_pending)
    );

    assign md_busy_eff = md_busy_q && !i_md_done;
    assign raw         = (uses_rs1 && rs1_pend) || (uses_rs2 && rs2_pend);
    assign waw         = writes_rd && rd_pend;
    assign struct_haz  = is_md && md_busy_eff;
    assign can_issue   = i_instr.valid && !raw && !waw && !struct_haz
                         && i_ex_ready && !i_flush && !i_rst;
    assign o_stall     = i_instr.valid && !can_issue && !i_flush && !i_rst;
    assign o_issue     = issue_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issue_q   <= '0;
            md_busy_q <= 1'b0;
        end else begin
            if (i_flush)        issue_q       <= '0;
            else if (can_issue) issue_q       <= i_instr;
            else                issue_q.valid <= 1'b0;

            // Issue-set takes priority over a same-cycle done.
            if (can_issue && is_md) md_busy_q <= 1'b1;
            else if (i_md_done)     md_busy_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int NUM_WB   = 2;

    logic                         i_clk = 1'b0;
    logic                         i_rst;
    logic                         i_flush;
    decoded_instr_t               i_instr;
    logic                         o_stall;
    logic                         i_ex_ready;
    decoded_instr_t               o_issue;
    logic [NUM_WB-1:0]            i_wb_valid;
    logic [NUM_WB-1:0][REG_W-1:0] i_wb_rd;
    logic                         i_md_done;
    logic [NUM_REGS-1:0]          o_sb_pending;

    int n_total = 0;
    int n_bad   = 0;
    decoded_instr_t exp_q[$];

    issue_scheduler #(.NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (i_flush),
        .i_instr      (i_instr),
        .o_stall      (o_stall),
        .i_ex_ready   (i_ex_ready),
        .o_issue      (o_issue),
        .i_wb_valid   (i_wb_valid),
        .i_wb_rd      (i_wb_rd),
        .i_md_done    (i_md_done),
        .o_sb_pending (o_sb_pending)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic decoded_instr_t mk(op_t op, int rd, int rs1, int rs2, int pc);
        decoded_instr_t d;
        d.valid   = 1'b1;
        d.exc     = EXCEPT_NONE;
        d.dec.op  = op;
        d.dec.rd  = REG_W'(rd);
        d.dec.rs1 = REG_W'(rs1);
        d.dec.rs2 = REG_W'(rs2);
        d.pc      = 32'(pc);
        return d;
    endfunction

    // Scoreboard consumer: every issued instruction must match the oldest expected one.
    always @(posedge i_clk) begin
        #1;
        if (o_issue.valid) begin
            if (exp_q.size() == 0) check("unexpected_issue", 64'(o_issue), 64'(0));
            else                   check("issue", 64'(o_issue), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle();
        i_instr    = '0;
        i_flush    = 1'b0;
        i_wb_valid = '0;
        i_wb_rd    = '0;
        i_md_done  = 1'b0;
        i_ex_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // Present a candidate expected to issue at the next edge.
    task automatic issue_now(input decoded_instr_t d, input string tag);
        i_instr = d;
        #1;
        check(tag, 64'(o_stall), 64'(0));
        exp_q.push_back(d);
        tick();
    endtask

    decoded_instr_t d;

    initial begin
        idle();
        i_rst = 1'b1;
        i_instr = mk(OP_ADD, 1, 2, 3, 'h10);
        #1;
        check("stall_in_reset", 64'(o_stall), 64'(0));
        tick();
        tick();
        check("rst_issue", 64'(o_issue), 64'(0));
        check("rst_sb", 64'(o_sb_pending), 64'(0));
        i_rst = 1'b0;
        i_instr = '0;

        // Independent stream plus one ex_ready back-pressure cycle.
        issue_now(mk(OP_ADD, 1, 0, 0, 'h100), "ind_stall1");
        issue_now(mk(OP_ADD, 2, 0, 0, 'h104), "ind_stall2");
        i_ex_ready = 1'b0;
        i_instr = mk(OP_ADD, 3, 0, 0, 'h108);
        #1;
        check("exready_stall", 64'(o_stall), 64'(1));
        tick();
        i_ex_ready = 1'b1;
        issue_now(mk(OP_ADD, 3, 0, 0, 'h108), "ind_stall3");
        i_instr = '0;
        check("ind_sb", 64'(o_sb_pending), 64'h0000_000E);

        // RAW released by same-cycle writeback.
        do_reset();
        issue_now(mk(OP_ADD, 5, 0, 0, 'h200), "raw_prod");
        i_instr = mk(OP_SUB, 6, 5, 7, 'h204);
        #1;
        check("raw_stall_a", 64'(o_stall), 64'(1));
        tick();
        check("raw_stall_b", 64'(o_stall), 64'(1));
        i_wb_valid = 2'b01;
        i_wb_rd[0] = 5'd5;
        issue_now(mk(OP_SUB, 6, 5, 7, 'h204), "raw_release");
        idle();
        check("raw_sb", 64'(o_sb_pending), 64'h0000_0040);

        // Structural hazard on mul/div.
        do_reset();
        issue_now(mk(OP_MUL, 1, 0, 0, 'h300), "md_mul");
        i_instr = mk(OP_DIV, 2, 3, 4, 'h304);
        #1;
        check("md_stall_a", 64'(o_stall), 64'(1));
        tick();
        check("md_stall_b", 64'(o_stall), 64'(1));
        i_md_done = 1'b1;
        issue_now(mk(OP_DIV, 2, 3, 4, 'h304), "md_div");
        i_md_done = 1'b0;
        i_instr = mk(OP_MUL, 8, 0, 0, 'h308);
        #1;
        check("md_busy_kept", 64'(o_stall), 64'(1));
        i_md_done = 1'b1;
        issue_now(mk(OP_MUL, 8, 0, 0, 'h308), "md_mul2");
        idle();
        check("md_sb", 64'(o_sb_pending), 64'h0000_0106);

        // Same-cycle set/clear of x4: set wins.
        do_reset();
        issue_now(mk(OP_ADD, 4, 0, 0, 'h400), "sc_first");
        i_wb_valid = 2'b10;
        i_wb_rd[1] = 5'd4;
        issue_now(mk(OP_ADD, 4, 1, 0, 'h404), "sc_second");
        idle();
        check("sc_sb", 64'(o_sb_pending), 64'h0000_0010);

        // x0 never tracked.
        do_reset();
        for (int i = 0; i < 4; i++) issue_now(mk(OP_ADD, 0, 0, 0, 'h500 + 4 * i), "x0_stall");
        i_instr = '0;
        check("x0_sb", 64'(o_sb_pending), 64'(0));

        // Fill every register, then exceptions must still issue.
        for (int i = 1; i < NUM_REGS; i++) issue_now(mk(OP_ADD, i, 0, 0, 'h600 + i), "fill");
        i_instr = '0;
        check("fill_sb", 64'(o_sb_pending), 64'hFFFF_FFFE);
        d = mk(OP_NOP, 0, 0, 0, 'h700);
        d.exc = EXCEPT_ILLEGAL;
        d.dec = NOP_DECODE;
        issue_now(d, "exc_nop");
        d = mk(OP_DIV, 1, 2, 3, 'h704);
        d.exc = EXCEPT_FETCH_FAULT;
        issue_now(d, "exc_div");
        i_instr = '0;
        check("exc_sb", 64'(o_sb_pending), 64'hFFFF_FFFE);

        // Flush a stalled candidate.
        i_instr = mk(OP_SUB, 9, 1, 2, 'h800);
        #1;
        check("fl_pre_stall", 64'(o_stall), 64'(1));
        tick();
        i_flush = 1'b1;
        #1;
        check("fl_stall", 64'(o_stall), 64'(0));
        tick();
        idle();
        check("fl_issue", 64'(o_issue), 64'(0));
        check("fl_sb", 64'(o_sb_pending), 64'hFFFF_FFFE);

        // Flush blocks a hazard-free issue and its scoreboard set.
        do_reset();
        i_instr = mk(OP_ADD, 10, 0, 0, 'h900);
        i_flush = 1'b1;
        tick();
        idle();
        check("fl_noset_sb", 64'(o_sb_pending), 64'(0));
        check("fl_noset_issue", 64'(o_issue), 64'(0));

        // Reset mid-stream.
        issue_now(mk(OP_MUL, 11, 0, 0, 'hA00), "mid_mul");
        issue_now(mk(OP_ADD, 12, 0, 0, 'hA04), "mid_add");
        i_instr = mk(OP_ADD, 13, 0, 0, 'hA08);
        i_rst = 1'b1;
        #1;
        check("mid_rst_stall", 64'(o_stall), 64'(0));
        tick();
        i_rst = 1'b0;
        check("mid_rst_issue", 64'(o_issue), 64'(0));
        check("mid_rst_sb", 64'(o_sb_pending), 64'(0));
        issue_now(mk(OP_MUL, 14, 0, 0, 'hA0C), "mid_md_free");
        idle();
        tick();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

In-order, single-issue scheduler between the decode stage and the execute units. It holds the decoded instruction presented by decode and checks it against a register scoreboard and a busy flag for the multi-cycle mul/div unit. It asserts stall back to decode until every hazard clears, then issues the instruction into a registered issue slot. The scoreboard is updated from the writeback ports.

## Interface
Parameters:
- NUM_REGS, 32, architectural integer registers; register 0 is hardwired zero.
- NUM_WB, 2, writeback ports that clear scoreboard bits.

Ports:
- i_clk  in  1  sole clock; all state updates on posedge.
- i_rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  kill the current issue-slot contents and the held candidate.
- i_instr  in  decoded_instr_t  candidate from decode; held stable by decode while o_stall=1.
- o_stall  out  1  combinational; to decode's stall input.
- i_ex_ready  in  1  execute can accept a new issue this cycle.
- o_issue  out  decoded_instr_t  registered issued instruction; valid bit inside.
- i_wb_valid  in  NUM_WB  writeback port strobes.
- i_wb_rd  in  NUM_WB x 5  destination register per writeback port.
- i_md_done  in  1  mul/div unit finished; frees the unit.
- o_sb_pending  out  NUM_REGS  scoreboard bits, for debug and assertions.

## Operation
- Reset or flush both force these values: o_issue='0; o_stall=0 while reset is asserted.
- Reset additionally clears the scoreboard and md_busy.
- Flush does not clear the scoreboard or md_busy. Already-issued instructions always write back.
- Hazard terms are evaluated only when i_instr.valid=1:
  - raw: rs1 is used and sb[rs1] is set, or rs2 is used and sb[rs2] is set.
  - waw: rd is written and sb[rd] is set.
  - struct: the instruction is mul/div and md_busy=1.
- Effective scoreboard: sb_eff = sb & ~wb_clear, where wb_clear is the OR of one-hot(i_wb_rd[k]) over ports with i_wb_valid[k]=1. Writeback in the same cycle therefore releases a waiting instruction.
- md_busy_eff = md_busy & ~i_md_done.
- can_issue = i_instr.valid & ~raw & ~waw & ~struct & i_ex_ready & ~i_flush.
- o_stall = i_instr.valid & ~can_issue & ~i_flush.
- On issue:
  - o_issue <= i_instr.
  - If rd is written and rd≠0, sb[rd] <= 1.
  - If the instruction is mul/div, md_busy <= 1.
- When not issuing: o_issue.valid <= 0 and the other o_issue fields hold.
- An instruction with an exception, or carrying NOP_DECODE, has no register use. It issues as soon as i_ex_ready=1 so the exception reaches execute in order.
- Register 0 is never set in the scoreboard and never causes a hazard.
- Same-cycle set and clear of the same register: the set from a new issue wins over a writeback clear.
- md_busy: an issue-set wins over i_md_done in the same cycle.

## Timing
- Candidate to o_issue latency: 1 cycle when hazard-free.
- A writeback in cycle N unblocks a dependent candidate so it issues at the edge ending cycle N.
- o_stall is combinational from i_instr, the scoreboard and the wb/md inputs; there are no combinational paths from o_issue.
- Issue throughput: one instruction per cycle.
- Flush in cycle N: o_issue.valid=0 after edge N; no scoreboard set occurs in cycle N.

## Structure
- The shared package (alongside decoded_instr_t, NOP_DECODE, EXCEPT_NONE) gains:
  - helper functions instr_uses_rs1/rs2, instr_writes_rd, instr_is_muldiv operating on decode_t;
  - REG_ZERO constant.
- Sub-module: sched_scoreboard. It owns the pending bits, the wb_clear merge, the set-wins rule, and the rs1/rs2/rd lookup ports.
- Top level: hazard logic, md_busy, issue register.

## Test plan
- Independent stream: add x1, add x2, add x3 with i_ex_ready=1 -> three consecutive o_issue.valid pulses; o_stall never 1; sb={x1,x2,x3}.
- RAW: issue add x5; next candidate sub x6,x5,x7 -> o_stall=1 until i_wb_valid[0]=1 with rd=5; the candidate issues at that same edge and sb[5]=0 while sb[6]=1.
- Structural: mul x1, then div x2 -> o_stall=1 until i_md_done; div issues the cycle i_md_done=1; md_busy stays 1.
- Same-cycle set/clear: a writeback to x4 while a candidate with rd=x4 issues (prior sb[4]=1 from an earlier writer) -> issue occurs and sb[4]=1 afterwards.
- x0 and exception: add x0 repeatedly -> never stalls and sb[0] stays 0; an instruction with a valid exception and NOP_DECODE issues despite every bit of sb being set.
- Flush/reset: flush during a stalled candidate -> o_issue.valid=0, o_stall=0, sb unchanged; i_rst for 1 cycle mid-stream -> sb=0, md_busy=0, o_issue='0.
